// File: rtl/control_pkg.sv
// control_pkg: shared definitions for the control sequencer.
//   - 4-bit opcode constants (instr[8:5])
//   - ALU operation codes driven on alu_op (PASS must be all-zero)
//   - FSM state encoding
//   - strobe bundle produced by the decoder
package control_pkg;

  localparam logic [3:0] OpNop    = 4'h0;
  localparam logic [3:0] OpCpyin  = 4'h1;
  localparam logic [3:0] OpCpyout = 4'h2;
  localparam logic [3:0] OpAdd    = 4'h3;
  localparam logic [3:0] OpSub    = 4'h4;
  localparam logic [3:0] OpAnd    = 4'h5;
  localparam logic [3:0] OpShl    = 4'h6;
  localparam logic [3:0] OpLoad   = 4'h7;
  localparam logic [3:0] OpStore  = 4'h8;
  localparam logic [3:0] OpCmp    = 4'h9;
  localparam logic [3:0] OpBeqz   = 4'hA;
  localparam logic [3:0] OpJmp    = 4'hB;
  localparam logic [3:0] OpHalt   = 4'hF;

  typedef enum logic [2:0] {
    AluPass = 3'b000,
    AluAdd  = 3'b001,
    AluSub  = 3'b010,
    AluAnd  = 3'b011,
    AluShl  = 3'b100
  } alu_op_e;

  typedef enum logic [1:0] {
    StFetch   = 2'b00,
    StExec    = 2'b01,
    StMemWait = 2'b10,
    StHalt    = 2'b11
  } state_e;

  typedef struct packed {
    logic cpyin;
    logic cpyout;
    logic mem_load;
    logic comp;
    logic mem_read;
    logic mem_write;
  } strobe_t;

endpackage

// File: rtl/instr_decode.sv
// instr_decode: combinational decode of the registered instruction and FSM state into
// register-file strobes, data-memory requests, ALU opcode and register select.
// Ports:
//   state_i     current FSM state
//   ir_i        registered instruction
//   mem_ready_i data-memory completion (only meaningful in MEM_WAIT)
//   strobe_o    cpyin/cpyout/memLoad/comp/mem_read/mem_write bundle
//   alu_op_o    ALU operation, PASS outside ALU/CMP execute cycles
//   reg_sel_o   register select, 0 when no register is addressed
module instr_decode
  import control_pkg::*;
(
  input  state_e      state_i,
  input  logic [8:0]  ir_i,
  input  logic        mem_ready_i,
  output strobe_t     strobe_o,
  output alu_op_e     alu_op_o,
  output logic [2:0]  reg_sel_o
);

  logic [3:0] op;
  logic [2:0] r;

  assign op = ir_i[8:5];
  assign r  = ir_i[2:0];

  always_comb begin
    strobe_o  = '0;
    alu_op_o  = AluPass;
    reg_sel_o = 3'd0;
    unique case (state_i)
      StExec: begin
        // LOAD/STORE issue nothing here; their requests start in MEM_WAIT.
        case (op)
          OpCpyin:  begin strobe_o.cpyin  = 1'b1; reg_sel_o = r; end
          OpCpyout: begin strobe_o.cpyout = 1'b1; reg_sel_o = r; end
          OpAdd:    begin alu_op_o = AluAdd; reg_sel_o = r; end
          OpSub:    begin alu_op_o = AluSub; reg_sel_o = r; end
          OpAnd:    begin alu_op_o = AluAnd; reg_sel_o = r; end
          OpShl:    begin alu_op_o = AluShl; reg_sel_o = r; end
          OpCmp:    begin strobe_o.comp = 1'b1; alu_op_o = AluSub; end
          default:  ;
        endcase
      end
      StMemWait: begin
        if (op == OpLoad) begin
          strobe_o.mem_read = 1'b1;
          if (mem_ready_i) begin
            strobe_o.mem_load = 1'b1;
            reg_sel_o         = r;
          end
        end else if (op == OpStore) begin
          strobe_o.mem_write = 1'b1;
          reg_sel_o          = r;
        end
      end
      StFetch, StHalt: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle FETCH/EXEC/MEM_WAIT/HALT sequencer in front of the
// accumulator register file. Owns pc, ir and branch resolution.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   imem_addr / instr   asynchronous instruction ROM (imem_addr == pc)
//   res_zero            datapath flag, sampled only in BEQZ execute
//   mem_ready           data-memory completion; mem_read/mem_write requests
//   cpyin/cpyout/memLoad/comp, reg_sel, alu_op   register-file controls
//   halted              core stopped after HALT
module control_sequencer
  import control_pkg::*;
#(
  parameter int unsigned PC_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  output logic [PC_W-1:0] imem_addr,
  input  logic [8:0]      instr,
  input  logic            res_zero,
  input  logic            mem_ready,
  output logic            mem_read,
  output logic            mem_write,
  output logic            cpyin,
  output logic            cpyout,
  output logic            memLoad,
  output logic            comp,
  output logic [2:0]      reg_sel,
  output logic [2:0]      alu_op,
  output logic            halted
);

  localparam logic [PC_W-1:0] PcOne = PC_W'(1);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [8:0]      ir_q, ir_d;

  logic [3:0]      op;
  logic [PC_W-1:0] imm_sext;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_rel;

  assign op       = ir_q[8:5];
  assign imm_sext = {{(PC_W-5){ir_q[4]}}, ir_q[4:0]};
  // Both sums wrap modulo 2^PC_W by truncation.
  assign pc_inc   = pc_q + PcOne;
  assign pc_rel   = pc_q + imm_sext;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    unique case (state_q)
      StFetch: begin
        ir_d    = instr;
        state_d = StExec;
      end
      StExec: begin
        state_d = StFetch;
        pc_d    = pc_inc;
        case (op)
          OpLoad, OpStore: begin
            state_d = StMemWait;
            pc_d    = pc_q;
          end
          OpBeqz:  pc_d = res_zero ? pc_rel : pc_inc;
          OpJmp:   pc_d = pc_rel;
          OpHalt:  state_d = StHalt;
          default: ;
        endcase
      end
      StMemWait: begin
        if (mem_ready) begin
          pc_d    = pc_inc;
          state_d = StFetch;
        end
      end
      StHalt: ;
    endcase
  end

  // Output logic
  strobe_t strobe;
  alu_op_e alu_op_w;

  instr_decode u_decode (
    .state_i     (state_q),
    .ir_i        (ir_q),
    .mem_ready_i (mem_ready),
    .strobe_o    (strobe),
    .alu_op_o    (alu_op_w),
    .reg_sel_o   (reg_sel)
  );

  always_comb begin
    imem_addr = pc_q;
    halted    = (state_q == StHalt);
    alu_op    = alu_op_w;
    cpyin     = strobe.cpyin;
    cpyout    = strobe.cpyout;
    memLoad   = strobe.mem_load;
    comp      = strobe.comp;
    mem_read  = strobe.mem_read;
    mem_write = strobe.mem_write;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Multi-cycle control sequencer sitting directly upstream of the accumulator register file. It fetches 9-bit instructions from an asynchronous instruction ROM, decodes them, and drives the file's `cpyin`, `cpyout`, `memLoad`, `comp`, and `reg_sel` strobes plus the ALU opcode and data-memory handshake. It also owns the PC and branch resolution, and guarantees that `res` is never clobbered outside ALU or compare instructions.

## Interface
- `PC_W`, 8: PC and instruction-address width.
- `clk`  in  1: single clock; all state updates on posedge. The register file samples strobes on the following negedge.
- `reset`  in  1: synchronous, active-high.
- `imem_addr`  out  PC_W: instruction address, equal to `pc`.
- `instr`  in  9: ROM data for `imem_addr`, valid in the same cycle.
- `res_zero`  in  1: datapath flag, 1 when `res_val == 0`.
- `mem_ready`  in  1: data-memory completion.
- `mem_read`, `mem_write`  out  1: data-memory request.
- `cpyin`, `cpyout`, `memLoad`, `comp`  out  1: register-file strobes.
- `reg_sel`  out  3: register select.
- `alu_op`  out  3: ALU operation; PASS=000 means `write_data = res_val`.
- `halted`  out  1: core stopped.

## Operation
- Instruction fields: `op = instr[8:5]`, `r = instr[2:0]`, `imm = instr[4:0]` (signed).
- NOP (0000): no strobes.
- CPYIN r (0001): `cpyin`=1, `reg_sel`=r, so `res <= r`.
- CPYOUT r (0010): `cpyout`=1, `reg_sel`=r.
- ALU ops ADD/SUB/AND/SHL r (0011–0110): `alu_op` = 001–100, `reg_sel`=r.
- LOAD r (0111): `mem_read` is held until `mem_ready`. In the `mem_ready` cycle, `memLoad`=1 and `reg_sel`=r.
- STORE r (1000): `mem_write` and `reg_sel`=r are held until `mem_ready`.
- CMP (1001): `comp`=1 and `alu_op`=SUB, giving `res <= reg7 - reg6`.
- BEQZ imm (1010): if `res_zero` is 1, `pc <= pc + sext(imm)`. Otherwise `pc <= pc + 1`.
- JMP imm (1011): `pc <= pc + sext(imm)`.
- HALT (1111): enter HALT.
- Undefined opcodes behave as NOP.
- `alu_op` is PASS in every cycle except the EXEC cycle of an ALU op or CMP. This is required because the file rewrites `res` from `write_data` on every negedge without `cpyin` or `memLoad`.
- FSM states:
  - FETCH: `ir <= instr`, go to EXEC.
  - EXEC: non-memory ops strobe, update `pc`, and go to FETCH. LOAD/STORE go to MEM_WAIT.
  - MEM_WAIT: on `mem_ready`, `pc <= pc+1` and go to FETCH.
  - HALT: absorbing until reset.
- PC arithmetic is modulo 2^PC_W. 0xFF+1 wraps to 0x00, and a branch target below 0 wraps.

## Timing
- Reset values: `pc`=0, `ir`=0, state=FETCH, `halted`=0, all strobes 0, `mem_read`/`mem_write` 0, `reg_sel`=0, `alu_op`=PASS.
- Strobes decode combinationally from the registered state and `ir`. They are stable before the mid-cycle negedge, high for exactly one cycle for non-memory ops, and never asserted in FETCH.
- Latency:
  - Non-memory instruction: 2 cycles.
  - LOAD/STORE: 2 + N cycles, where N ≥ 1 is the number of MEM_WAIT cycles up to and including the `mem_ready` cycle.
- `mem_ready` outside MEM_WAIT is ignored.
- `mem_ready` in the first MEM_WAIT cycle completes immediately (N=1).
- `res_zero` is sampled only in BEQZ's EXEC cycle.
- Reset during MEM_WAIT aborts the access. `mem_read`/`mem_write` drop in the cycle after the reset edge, and no `memLoad` is issued.
- In HALT all outputs hold their reset-inactive values, `halted`=1, and `pc` is frozen at HALT's address + 1.

## Structure
- Shared package `control_pkg`:
  - opcode constants;
  - `alu_op` codes (PASS, ADD, SUB, AND, SHL);
  - FSM state encoding (FETCH, EXEC, MEM_WAIT, HALT).
- Sub-module `instr_decode`: combinational `ir` + state → strobe bundle, `alu_op`, and `reg_sel`. The top level holds the FSM, `pc`, and `ir`.

## Test plan
- Reset, then ROM 0x00 = CPYIN 3 (0x023) → the EXEC cycle has `cpyin`=1, `reg_sel`=3, `alu_op`=000; `pc` reads 1 on the second posedge.
- ADD 2 (0x062) followed by NOP → `alu_op`=001 for exactly one cycle, then 000 in FETCH and NOP EXEC.
- LOAD 5 (0x0E5) with `mem_ready` delayed 3 cycles → `mem_read` held 3 cycles, `memLoad`=1 with `reg_sel`=5 only in the last; instruction takes 5 cycles; no extra `memLoad` after reset asserted mid-wait.
- BEQZ −2 (0x15E) at pc=0x01:
  - `res_zero`=1 → next fetch at 0xFF.
  - `res_zero`=0 → next fetch at 0x02.
- JMP +1 (0x161) at pc=0xFF → next fetch at 0x00 (wrap).
- HALT (0x1E0) at pc=0x04 → `halted`=1, `pc`=0x05 frozen, all strobes 0, `mem_ready` pulses ignored; reset returns to pc=0.
